box_motion_control: RTL and testbench



---
 rtl/box_motion_control.sv | 137 +++++++++++++
 tb/tb_box_motion_control.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/box_motion_control.sv
// Control FSM for the bouncing 4x4 square. It sequences draw/wait/erase/move
// frames and drives the square datapath position and strobes.
module box_motion_control #(
  parameter int unsigned FRAME_CYCLES = 833334,
  parameter int unsigned X_MAX        = 156,
  parameter int unsigned Y_MAX        = 116
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       stop,
  input  logic [7:0] start_x,
  input  logic [6:0] start_y,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       load_x,
  output logic       load_y,
  output logic       draw,
  output logic       erase,
  output logic       plot,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAW, WAIT, ERASE, MOVE, HALT_ERASE
  } state_t;

  localparam int unsigned   FW         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [7:0]    XM         = 8'(X_MAX);
  localparam logic [6:0]    YM         = 7'(Y_MAX);

  state_t        state, state_next;
  logic [3:0]    pix_cnt;
  logic [FW-1:0] frame_cnt;
  logic          dir_x, dir_y;
  logic          pix_last, frame_last;

  assign pix_last   = (pix_cnt == 4'hF);
  assign frame_last = (frame_cnt == FRAME_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_x     = 1'b0;
    load_y     = 1'b0;
    draw       = 1'b0;
    erase      = 1'b0;
    case (state)
      IDLE:       if (go) state_next = LOAD;
      LOAD: begin
        load_x     = 1'b1;
        load_y     = 1'b1;
        state_next = DRAW;
      end
      DRAW: begin
        draw = 1'b1;
        if (pix_last) state_next = WAIT;
      end
      // stop only matters on the cycle the frame delay expires
      WAIT:       if (frame_last) state_next = stop ? HALT_ERASE : ERASE;
      ERASE: begin
        erase = 1'b1;
        if (pix_last) state_next = MOVE;
      end
      MOVE: begin
        load_x     = 1'b1;
        load_y     = 1'b1;
        state_next = DRAW;
      end
      HALT_ERASE: begin
        erase = 1'b1;
        if (pix_last) state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
    plot = draw | erase;
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt   <= '0;
      frame_cnt <= '0;
      x_pos     <= '0;
      y_pos     <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else begin
      // 4-bit counter wraps to 0 on its own after the 16th burst cycle
      pix_cnt   <= (state == DRAW || state == ERASE || state == HALT_ERASE) ? pix_cnt + 4'd1 : '0;
      frame_cnt <= (state == WAIT && !frame_last) ? frame_cnt + FW'(1) : '0;
      if (state == LOAD) begin
        x_pos <= (start_x > XM) ? XM : start_x;
        y_pos <= (start_y > YM) ? YM : start_y;
        dir_x <= 1'b1;
        dir_y <= 1'b1;
      end else if (state == MOVE) begin
        if (dir_x) begin
          if (x_pos == XM) begin
            dir_x <= 1'b0;
            x_pos <= x_pos - 8'd1;
          end else begin
            x_pos <= x_pos + 8'd1;
          end
        end else begin
          if (x_pos == '0) begin
            dir_x <= 1'b1;
            x_pos <= x_pos + 8'd1;
          end else begin
            x_pos <= x_pos - 8'd1;
          end
        end
        if (dir_y) begin
          if (y_pos == YM) begin
            dir_y <= 1'b0;
            y_pos <= y_pos - 7'd1;
          end else begin
            y_pos <= y_pos + 7'd1;
          end
        end else begin
          if (y_pos == '0) begin
            dir_y <= 1'b1;
            y_pos <= y_pos + 7'd1;
          end else begin
            y_pos <= y_pos - 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_box_motion_control.sv
// Bench for box_motion_control: frame timing and bounce positions are
// predicted from elapsed cycles using a reflection formula.
module tb_box_motion_control;

  localparam int F  = 4;
  localparam int P  = 16 + F + 16 + 1;
  localparam int XM = 156;
  localparam int YM = 116;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] start_x = '0;
  logic [6:0] start_y = '0;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       load_x, load_y, draw, erase, plot, busy;

  int total = 0;
  int bad   = 0;

  box_motion_control #(.FRAME_CYCLES(F), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .stop(stop),
    .start_x(start_x), .start_y(start_y), .x_pos(x_pos), .y_pos(y_pos),
    .load_x(load_x), .load_y(load_y), .draw(draw), .erase(erase),
    .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Position after k moves starting at p0 heading up: a reflection in [0,m].
  function automatic int bounce(input int p0, input int k, input int m);
    int u;
    u = (p0 + k) % (2 * m);
    return (u <= m) ? u : 2 * m - u;
  endfunction

  // t counts cycles since LOAD (t=0).
  task automatic check_cycle(input int t, input int x0, input int y0);
    int o, k, ed, ee, el;
    if (t == 0) begin
      ed = 0; ee = 0; el = 1; k = 0;
    end else begin
      o  = (t - 1) % P;
      k  = (t - 1) / P;
      ed = (o < 16) ? 1 : 0;
      ee = (o >= 16 + F && o < 32 + F) ? 1 : 0;
      el = (o == P - 1) ? 1 : 0;
    end
    chk("draw",   32'(draw),   ed);
    chk("erase",  32'(erase),  ee);
    chk("plot",   32'(plot),   ed | ee);
    chk("load_x", 32'(load_x), el);
    chk("load_y", 32'(load_y), el);
    chk("busy",   32'(busy),   1);
    if (t > 0) begin
      chk("x_pos", 32'(x_pos), bounce(x0, k, XM));
      chk("y_pos", 32'(y_pos), bounce(y0, k, YM));
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_draw"},  32'(draw),   0);
    chk({tag, "_erase"}, 32'(erase),  0);
    chk({tag, "_plot"},  32'(plot),   0);
    chk({tag, "_load"},  32'(load_x | load_y), 0);
    chk({tag, "_busy"},  32'(busy),   0);
  endtask

  task automatic start_run(input int sx, input int sy);
    @(negedge clock);
    reset_n = 1'b0;
    go      = 1'b0;
    stop    = 1'b0;
    start_x = 8'(sx);
    start_y = 7'(sy);
    #1;
    check_quiet("rst");
    chk("rst_x", 32'(x_pos), 0);
    chk("rst_y", 32'(y_pos), 0);
    @(negedge clock);
    reset_n = 1'b1;
    go      = 1'b1;
  endtask

  task automatic run_scenario(input int sx, input int sy, input int cycles);
    int cx, cy;
    cx = (sx > XM) ? XM : sx;
    cy = (sy > YM) ? YM : sy;
    start_run(sx, sy);
    for (int t = 0; t <= cycles; t++) begin
      @(negedge clock);
      check_cycle(t, cx, cy);
    end
  endtask

  initial begin
    // Directed frames: basic, right edge, corner, clamp, origin
    run_scenario(10, 20, 3 * P);
    run_scenario(156, 50, 3 * P);
    run_scenario(156, 116, 2 * P);
    run_scenario(200, 127, 2 * P);
    run_scenario(0, 0, 2 * P);

    // Random starting points, long enough to reach bounces near edges
    for (int i = 0; i < 4; i++) begin
      run_scenario(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 4 * P);
    end

    // Clean stop requested during WAIT
    start_run(30, 40);
    for (int t = 0; t <= 20; t++) begin
      @(negedge clock);
      check_cycle(t, 30, 40);
      if (t == 17) stop = 1'b1;
      if (t == 20) go = 1'b0;
    end
    for (int t = 21; t <= 36; t++) begin
      @(negedge clock);
      stop = 1'b0;
      chk("halt_erase", 32'(erase), 1);
      chk("halt_draw",  32'(draw),  0);
      chk("halt_busy",  32'(busy),  1);
      chk("halt_x",     32'(x_pos), 30);
      chk("halt_y",     32'(y_pos), 40);
    end
    for (int t = 37; t <= 39; t++) begin
      @(negedge clock);
      check_quiet("idle");
      chk("idle_x", 32'(x_pos), 30);
      chk("idle_y", 32'(y_pos), 40);
    end
    go = 1'b1;
    for (int t = 0; t <= P; t++) begin
      @(negedge clock);
      check_cycle(t, 30, 40);
    end

    // Asynchronous reset in the middle of a draw burst
    start_run(50, 60);
    for (int t = 0; t <= 7; t++) begin
      @(negedge clock);
      check_cycle(t, 50, 60);
    end
    reset_n = 1'b0;
    #1;
    check_quiet("async");
    chk("async_x", 32'(x_pos), 0);
    chk("async_y", 32'(y_pos), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int t = 0; t <= P + 1; t++) begin
      @(negedge clock);
      check_cycle(t, 50, 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
